// File: rtl/logic_table_sequencer.sv
// logic_table_sequencer
// Steps an external combinational 2-input logic unit through ab = 00, 01, 10, 11 for one
// op, or for every op 0..NUM_OPS-1 in sweep mode. Each fu_s sample goes into a 4-bit
// truth-table signature, which is returned over a valid/ready handshake.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start, sweep_all      run request (taken only when idle); sweep_all selects all-op sweep
//   op_sel                op code for a single run (values >= NUM_OPS are passed through)
//   fu_op, fu_a, fu_b     registered drive to the function unit
//   fu_s                  function unit result, combinational from fu_op/fu_a/fu_b
//   busy                  high whenever the FSM is not idle
//   res_valid, res_ready  result handshake
//   res_op, res_table     op and captured table (bit i = fu_s with {fu_a,fu_b} = i)
//   res_err               golden-table mismatch, valid with res_valid
//
// Optional feature: define LOGIC_SEQ_CHECK_EN to build a golden ROM and drive res_err.
// Without it, res_err is tied to 0.
// Op codes are 3 bits wide, so NUM_OPS must be 1..8.

module logic_table_sequencer #(
  parameter int unsigned NUM_OPS       = 5,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sweep_all,
  input  logic [2:0] op_sel,
  output logic [2:0] fu_op,
  output logic       fu_a,
  output logic       fu_b,
  input  logic       fu_s,
  output logic       busy,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [2:0] res_op,
  output logic [3:0] res_table,
  output logic       res_err
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LastOp = 3'(NUM_OPS - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StResult} state_e;

  state_e          state_q;
  logic            sweep_q;
  logic [1:0]      idx_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      table_next;
  logic            err_next;

  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StResult);

  // Table including the sample taken on the current edge; used so that the final
  // golden compare sees all four bits in the same cycle the FSM enters RESULT.
  always_comb begin
    table_next        = res_table;
    table_next[idx_q] = fu_s;
  end

`ifdef LOGIC_SEQ_CHECK_EN
  localparam logic [3:0] NumOpsW = 4'(NUM_OPS);

  function automatic logic [3:0] golden(input logic [2:0] op);
    case (op)
      3'd0:    golden = 4'h2;  // ~a & b
      3'd1:    golden = 4'hD;  // a | ~b
      3'd2:    golden = 4'h6;  // a ^ b
      3'd3:    golden = 4'h9;  // ~(a ^ b)
      3'd4:    golden = 4'h6;  // (a | b) & (~a | ~b)
      default: golden = 4'h0;
    endcase
  endfunction

  // Out-of-range ops have no golden entry and never flag an error.
  assign err_next = ({1'b0, fu_op} < NumOpsW) && (table_next != golden(fu_op));
`else
  assign err_next = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sweep_q   <= 1'b0;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      fu_op     <= 3'd0;
      fu_a      <= 1'b0;
      fu_b      <= 1'b0;
      res_op    <= 3'd0;
      res_table <= 4'd0;
      res_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StDrive;
            sweep_q      <= sweep_all;
            fu_op        <= sweep_all ? 3'd0 : op_sel;
            {fu_a, fu_b} <= 2'b00;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            res_table    <= 4'd0;
          end
        end
        StDrive: begin
          if (cnt_q == CntLast) begin
            cnt_q     <= '0;
            res_table <= table_next;
            if (idx_q == 2'd3) begin
              // Vector stays at 11 while the result waits for the consumer.
              state_q <= StResult;
              res_op  <= fu_op;
              res_err <= err_next;
            end else begin
              idx_q        <= idx_q + 2'd1;
              {fu_a, fu_b} <= idx_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResult: begin
          if (res_ready) begin
            if (sweep_q && (fu_op < LastOp)) begin
              state_q      <= StDrive;
              fu_op        <= fu_op + 3'd1;
              {fu_a, fu_b} <= 2'b00;
              idx_q        <= 2'd0;
              cnt_q        <= '0;
              res_table    <= 4'd0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_table_sequencer.sv
// Bench for logic_table_sequencer: two instances (SETTLE_CYCLES = 1 and 3) share stimulus,
// each driven by its own function-unit model. A timeline model (elapsed cycles since the
// start of each op) predicts every output on every cycle; directed runs pin literal tables.

module tb_logic_table_sequencer;

  localparam int NumOps = 5;
  localparam int S0     = 1;
  localparam int S1     = 3;
  localparam logic [3:0] Gold [5] = '{4'h2, 4'hD, 4'h6, 4'h9, 4'h6};
`ifdef LOGIC_SEQ_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            sweep_all;
  logic            res_ready;
  logic            fault0;
  logic [2:0]      op_sel;
  logic [1:0]      o_busy, o_valid, o_a, o_b, o_err, fu_s;
  logic [1:0][2:0] o_fu_op, o_rop;
  logic [1:0][3:0] o_tab;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rmode    = 0;
  int vcnt     = 0;

  logic_table_sequencer #(.NUM_OPS(NumOps), .SETTLE_CYCLES(S0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .sweep_all(sweep_all), .op_sel(op_sel),
    .fu_op(o_fu_op[0]), .fu_a(o_a[0]), .fu_b(o_b[0]), .fu_s(fu_s[0]), .busy(o_busy[0]),
    .res_valid(o_valid[0]), .res_ready(res_ready), .res_op(o_rop[0]),
    .res_table(o_tab[0]), .res_err(o_err[0])
  );

  logic_table_sequencer #(.NUM_OPS(NumOps), .SETTLE_CYCLES(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sweep_all(sweep_all), .op_sel(op_sel),
    .fu_op(o_fu_op[1]), .fu_a(o_a[1]), .fu_b(o_b[1]), .fu_s(fu_s[1]), .busy(o_busy[1]),
    .res_valid(o_valid[1]), .res_ready(res_ready), .res_op(o_rop[1]),
    .res_table(o_tab[1]), .res_err(o_err[1])
  );

  // Function unit; flt makes op0 behave as ~a (table 4'h3).
  function automatic logic unit_out(input logic [2:0] op, input logic [1:0] v, input bit flt);
    logic a, b;
    a = v[1];
    b = v[0];
    case (op)
      3'd0:    unit_out = flt ? ~a : (~a & b);
      3'd1:    unit_out = a | ~b;
      3'd2:    unit_out = a ^ b;
      3'd3:    unit_out = ~(a ^ b);
      3'd4:    unit_out = (a | b) & (~a | ~b);
      default: unit_out = a & b;
    endcase
  endfunction

  assign fu_s[0] = unit_out(o_fu_op[0], {o_a[0], o_b[0]}, fault0);
  assign fu_s[1] = unit_out(o_fu_op[1], {o_a[1], o_b[1]}, fault0);

  function automatic int settle(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic logic exp_err(input logic [2:0] op, input bit flt);
    logic [3:0] t;
    for (int v = 0; v < 4; v++) t[v] = unit_out(op, 2'(v), flt);
    if (!ChkEn || int'(op) >= NumOps) return 1'b0;
    return t != Gold[op];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timeline model: m_k counts cycles since the current op began; the vector in force is
  // m_k / S, a sample lands every S cycles, and the result appears at m_k == 4*S.
  logic       m_act [2];
  int         m_k   [2];
  logic [2:0] m_op  [2];
  logic [2:0] m_rop [2];
  logic       m_sw  [2];
  logic       m_err [2];
  logic [3:0] m_tab [2];
  logic [1:0] m_ab  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0; m_k[i] <= 0; m_op[i] <= 3'd0; m_rop[i] <= 3'd0;
        m_sw[i] <= 1'b0; m_err[i] <= 1'b0; m_tab[i] <= 4'd0; m_ab[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_act[i]) begin
          if (start) begin
            m_act[i] <= 1'b1;
            m_k[i]   <= 0;
            m_sw[i]  <= sweep_all;
            m_op[i]  <= sweep_all ? 3'd0 : op_sel;
            m_tab[i] <= 4'd0;
            m_ab[i]  <= 2'd0;
          end
        end else if (m_k[i] < 4 * settle(i)) begin
          m_k[i] <= m_k[i] + 1;
          if ((m_k[i] + 1) % settle(i) == 0) begin
            m_tab[i][(m_k[i] + 1) / settle(i) - 1] <=
              unit_out(m_op[i], 2'((m_k[i] + 1) / settle(i) - 1), fault0);
            if ((m_k[i] + 1) / settle(i) < 4) begin
              m_ab[i] <= 2'((m_k[i] + 1) / settle(i));
            end else begin
              m_rop[i] <= m_op[i];
              m_err[i] <= exp_err(m_op[i], fault0);
            end
          end
        end else if (res_ready) begin
          if (m_sw[i] && int'(m_op[i]) < NumOps - 1) begin
            m_op[i]  <= m_op[i] + 3'd1;
            m_k[i]   <= 0;
            m_tab[i] <= 4'd0;
            m_ab[i]  <= 2'd0;
          end else begin
            m_act[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(m_act[i]));
      check($sformatf("res_valid%0d", i), 32'(o_valid[i]),
            32'(m_act[i] && m_k[i] == 4 * settle(i)));
      check($sformatf("fu_op%0d", i), 32'(o_fu_op[i]), 32'(m_op[i]));
      check($sformatf("fu_ab%0d", i), 32'({o_a[i], o_b[i]}), 32'(m_ab[i]));
      check($sformatf("res_op%0d", i), 32'(o_rop[i]), 32'(m_rop[i]));
      check($sformatf("res_table%0d", i), 32'(o_tab[i]), 32'(m_tab[i]));
      if (m_act[i] && m_k[i] == 4 * settle(i))
        check($sformatf("res_err%0d", i), 32'(o_err[i]), 32'(m_err[i]));
    end
  end

  // Capture each result as res_valid rises, and log instance-0 transfers in order.
  logic [1:0] v_prev = 2'b00;
  int         rise_cyc [2];
  logic [3:0] cap_tab  [2];
  logic [2:0] cap_op   [2];
  logic       cap_err  [2];
  logic [3:0] q_tab [$];
  logic [2:0] q_op  [$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      v_prev[i] <= o_valid[i];
      if (o_valid[i] && !v_prev[i]) begin
        rise_cyc[i] <= cyc;
        cap_tab[i]  <= o_tab[i];
        cap_op[i]   <= o_rop[i];
        cap_err[i]  <= o_err[i];
      end
    end
    if (rst_n && o_valid[0] && res_ready) begin
      q_tab.push_back(o_tab[0]);
      q_op.push_back(o_rop[0]);
    end
  end

  // res_ready: 0 = always high, 1 = low for 5 cycles of each result, else random.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      vcnt = (|o_valid) ? vcnt + 1 : 0;
      case (rmode)
        0:       res_ready = 1'b1;
        1:       res_ready = (vcnt >= 6);
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic wait_idle(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (o_busy == 2'b00) return;
    end
    check("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  task automatic start_pulse(input bit sw, input logic [2:0] op, output int acc);
    @(posedge clk);
    #2;
    start = 1'b1; sweep_all = sw; op_sel = op;
    @(posedge clk);
    #1;
    acc = cyc;
    #1;
    start = 1'b0;
  endtask

  task automatic run(input bit sw, input logic [2:0] op, output int acc);
    wait_idle(400);
    start_pulse(sw, op, acc);
    wait_idle(400);
  endtask

  initial begin
    int acc;
    rst_n = 1'b1; start = 1'b0; sweep_all = 1'b0; op_sel = 3'd0; fault0 = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", 32'({o_busy, o_valid, o_a, o_b, o_err, o_fu_op, o_rop, o_tab}), 0);

    // Single op2, ready high: latency 4 / 12, busy drops one cycle after transfer.
    start_pulse(1'b0, 3'd2, acc);
    for (int n = 0; n < 20 && !o_valid[0]; n++) @(negedge clk);
    check("op2_valid_seen", 32'(o_valid[0]), 32'd1);
    @(negedge clk);
    check("op2_busy_drop", 32'(o_busy[0]), 32'd0);
    wait_idle(400);
    check("op2_latency_s1", 32'(rise_cyc[0] - acc), 32'd4);
    check("op2_latency_s3", 32'(rise_cyc[1] - acc), 32'd12);
    check("op2_table", 32'(cap_tab[0]), 32'h6);
    check("op2_res_op", 32'(cap_op[0]), 32'd2);
    check("op2_err", 32'(cap_err[0]), 32'd0);

    // Single op1: SETTLE_CYCLES = 3 instance holds each vector 3 cycles.
    run(1'b0, 3'd1, acc);
    check("op1_latency_s3", 32'(rise_cyc[1] - acc), 32'd12);
    check("op1_table_s3", 32'(cap_tab[1]), 32'hD);
    check("op1_table_s1", 32'(cap_tab[0]), 32'hD);

    // Sweep with backpressure.
    rmode = 1;
    wait_idle(400);
    q_tab.delete(); q_op.delete();
    run(1'b1, 3'd0, acc);
    rmode = 0;
    check("sweep_count", 32'(q_tab.size()), 32'd5);
    for (int j = 0; j < 5 && j < q_tab.size(); j++) begin
      check($sformatf("sweep_op%0d", j), 32'(q_op[j]), 32'(j));
      check($sformatf("sweep_table%0d", j), 32'(q_tab[j]), 32'(Gold[j]));
    end

    // Start pulsed mid-run is ignored.
    wait_idle(400);
    q_tab.delete(); q_op.delete();
    start_pulse(1'b0, 3'd3, acc);
    @(posedge clk);
    #2 start = 1'b1; op_sel = 3'd1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_idle(400);
    check("midstart_count", 32'(q_tab.size()), 32'd1);
    check("midstart_op", 32'(q_op.size() > 0 ? q_op[0] : 3'd0), 32'd3);
    check("midstart_table", 32'(q_tab.size() > 0 ? q_tab[0] : 4'd0), 32'h9);

    // Out-of-range op passes through.
    run(1'b0, 3'd7, acc);
    check("op7_res_op", 32'(cap_op[0]), 32'd7);
    check("op7_err", 32'(cap_err[0]), 32'd0);
    check("op7_table", 32'(cap_tab[0]), 32'h8);

    // Reset after the second sample of an op2 run.
    wait_idle(400);
    start_pulse(1'b0, 3'd2, acc);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          32'({o_busy, o_valid, o_a, o_b, o_err, o_fu_op, o_rop, o_tab}), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid_quiet", 32'({o_busy, o_valid}), 32'd0);
    run(1'b0, 3'd3, acc);
    check("post_rst_op3_s1", 32'(cap_tab[0]), 32'h9);
    check("post_rst_op3_s3", 32'(cap_tab[1]), 32'h9);

    // Faulted op0 unit.
    fault0 = 1'b1;
    run(1'b0, 3'd0, acc);
    check("fault_table", 32'(cap_tab[0]), 32'h3);
    check("fault_err", 32'(cap_err[0]), 32'(ChkEn));
    check("fault_err_s3", 32'(cap_err[1]), 32'(ChkEn));
    fault0 = 1'b0;

    // Random traffic, random backpressure and occasional resets.
    rmode = 2;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #2;
      rst_n     = ($urandom_range(0, 299) != 0);
      start     = ($urandom_range(0, 3) == 0);
      sweep_all = ($urandom_range(0, 5) == 0);
      op_sel    = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    #2 rst_n = 1'b1; start = 1'b0;
    rmode = 0;
    wait_idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
